riscv_dmem_arb: RTL and testbench

RISCV_DMEM_ARB -- requirements
Module: riscv_dmem_arb

---
 rtl/riscv_dmem_arb.sv | 177 +++++++++++++++++
 tb/tb_riscv_dmem_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_arb.sv
// riscv_dmem_arb
//   Arbitrates two LSU pipes onto one DCACHE port. A pipe that wins the
//   arbitration owns the port until its transaction completes. While it owns
//   the port, the owner's request is passed through combinationally and the
//   DCACHE acks are steered back to it. Ties are broken against the pipe that
//   was granted last. A watchdog abandons a read whose data never returns.
//
// Ports
//   clk, srst_n                  clock, async active-low reset
//   pN_read_req / pN_write_req   pipe N load request / store byte-enables
//   pN_addr / pN_write_data      pipe N address / store data
//   pN_busy                      pipe N stall
//   pN_read_ack / pN_write_ack   routed DCACHE acks
//   pN_rdata_val                 routed read-data valid
//   rdata_out                    DCACHE rdata broadcast to both pipes
//   dcache_busy, read_ack, write_ack, rdata_val, rdata   DCACHE status/data
//   read_req, write_req, addr, write_data                DCACHE request
//   timeout_err                  one-cycle pulse when a read is abandoned
module riscv_dmem_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  srst_n,
   input  logic                  p0_read_req,
   input  logic                  p1_read_req,
   input  logic [3:0]            p0_write_req,
   input  logic [3:0]            p1_write_req,
   input  logic [31:0]           p0_addr,
   input  logic [31:0]           p1_addr,
   input  logic [DATA_WIDTH-1:0] p0_write_data,
   input  logic [DATA_WIDTH-1:0] p1_write_data,
   output logic                  p0_busy,
   output logic                  p1_busy,
   output logic                  p0_read_ack,
   output logic                  p1_read_ack,
   output logic                  p0_write_ack,
   output logic                  p1_write_ack,
   output logic                  p0_rdata_val,
   output logic                  p1_rdata_val,
   output logic [DATA_WIDTH-1:0] rdata_out,
   input  logic                  dcache_busy,
   input  logic                  read_ack,
   input  logic                  write_ack,
   input  logic                  rdata_val,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  read_req,
   output logic [3:0]            write_req,
   output logic [31:0]           addr,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0] r_state, w_next;
   logic       r_owner, w_owner_n;
   logic       r_last, w_last_n;
   logic [7:0] r_cnt, w_cnt_n, w_cnt_inc;

   logic                  w_p0_req, w_p1_req;
   logic                  w_in_own, w_in_wait, w_active;
   logic                  w_own_rd, w_own_req, w_done, w_expire;
   logic [3:0]            w_own_wr;
   logic [31:0]           w_own_addr;
   logic [DATA_WIDTH-1:0] w_own_wdata;
   logic                  w_rack, w_wack, w_rval;

   assign w_p0_req  = p0_read_req | (|p0_write_req);
   assign w_p1_req  = p1_read_req | (|p1_write_req);
   assign w_in_own  = (r_state == S_OWN);
   assign w_in_wait = (r_state == S_WAIT);
   assign w_active  = w_in_own | w_in_wait;

   assign w_own_rd    = r_owner ? p1_read_req   : p0_read_req;
   assign w_own_wr    = r_owner ? p1_write_req  : p0_write_req;
   assign w_own_addr  = r_owner ? p1_addr       : p0_addr;
   assign w_own_wdata = r_owner ? p1_write_data : p0_write_data;
   assign w_own_req   = w_own_rd | (|w_own_wr);

   // w_cnt_inc counts WAIT_DATA cycles including the current one, so the
   // read expires on the TIMEOUT-th cycle; returning data in that cycle wins.
   assign w_cnt_inc = r_cnt + 8'd1;
   assign w_expire  = w_in_wait & ~rdata_val & (w_cnt_inc == 8'(TIMEOUT));

   always_comb begin
      w_next    = r_state;
      w_owner_n = r_owner;
      w_last_n  = r_last;
      w_cnt_n   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_p0_req && w_p1_req) begin
               w_next    = S_OWN;
               w_owner_n = ~r_last;
            end else if (w_p0_req) begin
               w_next    = S_OWN;
               w_owner_n = 1'b0;
            end else if (w_p1_req) begin
               w_next    = S_OWN;
               w_owner_n = 1'b1;
            end
         end
         S_OWN: begin
            if (read_ack) begin
               if (rdata_val) begin
                  w_next   = S_IDLE;
                  w_last_n = r_owner;
               end else begin
                  w_next  = S_WAIT;
                  w_cnt_n = 8'd0;
               end
            end else if (write_ack) begin
               w_next   = S_IDLE;
               w_last_n = r_owner;
            end else if (!w_own_req) begin
               // abort: fairness history is left untouched
               w_next = S_IDLE;
            end
         end
         S_WAIT: begin
            w_cnt_n = w_cnt_inc;
            if (rdata_val || w_expire) begin
               w_next   = S_IDLE;
               w_last_n = r_owner;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         r_state <= S_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next;
         r_owner <= w_owner_n;
         r_last  <= w_last_n;
         r_cnt   <= w_cnt_n;
      end
   end

   // DCACHE side: only the owner's request, and only while in OWN.
   // A read masks any simultaneous write from the same pipe.
   assign read_req   = w_in_own & w_own_rd;
   assign write_req  = (w_in_own && !w_own_rd) ? w_own_wr : 4'd0;
   assign addr       = w_in_own ? w_own_addr  : 32'd0;
   assign write_data = w_in_own ? w_own_wdata : '0;

   // Acks only count in OWN; data valid counts with read_ack in OWN or in
   // WAIT_DATA. Anything else (IDLE, stray acks in WAIT_DATA) is dropped.
   assign w_rack = w_in_own & read_ack;
   assign w_wack = w_in_own & write_ack;
   assign w_rval = (w_in_own & read_ack & rdata_val) | (w_in_wait & rdata_val);

   assign p0_read_ack  = w_rack & ~r_owner;
   assign p1_read_ack  = w_rack &  r_owner;
   assign p0_write_ack = w_wack & ~r_owner;
   assign p1_write_ack = w_wack &  r_owner;
   assign p0_rdata_val = w_rval & ~r_owner;
   assign p1_rdata_val = w_rval &  r_owner;

   // Owner stalls until its completing event; a requesting non-owner stalls
   // for the whole transaction. Busy is gated so reset forces it low.
   assign w_done  = w_in_own ? (read_ack | write_ack) : rdata_val;
   assign p0_busy = srst_n & (dcache_busy | (w_active & (r_owner ? w_p0_req : ~w_done)));
   assign p1_busy = srst_n & (dcache_busy | (w_active & (r_owner ? ~w_done : w_p1_req)));

   assign timeout_err = w_expire;
   assign rdata_out   = rdata;

endmodule

// File: tb/tb_riscv_dmem_arb.sv
module tb_riscv_dmem_arb;

   logic        clk = 1'b0;
   logic        srst_n;
   logic        p0_read_req, p1_read_req;
   logic [3:0]  p0_write_req, p1_write_req;
   logic [31:0] p0_addr, p1_addr, p0_write_data, p1_write_data;
   logic        p0_busy, p1_busy, p0_read_ack, p1_read_ack;
   logic        p0_write_ack, p1_write_ack, p0_rdata_val, p1_rdata_val;
   logic [31:0] rdata_out, rdata, addr, write_data;
   logic        dcache_busy, read_ack, write_ack, rdata_val, read_req, timeout_err;
   logic [3:0]  write_req;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   riscv_dmem_arb #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .srst_n(srst_n),
      .p0_read_req(p0_read_req), .p1_read_req(p1_read_req),
      .p0_write_req(p0_write_req), .p1_write_req(p1_write_req),
      .p0_addr(p0_addr), .p1_addr(p1_addr),
      .p0_write_data(p0_write_data), .p1_write_data(p1_write_data),
      .p0_busy(p0_busy), .p1_busy(p1_busy),
      .p0_read_ack(p0_read_ack), .p1_read_ack(p1_read_ack),
      .p0_write_ack(p0_write_ack), .p1_write_ack(p1_write_ack),
      .p0_rdata_val(p0_rdata_val), .p1_rdata_val(p1_rdata_val),
      .rdata_out(rdata_out),
      .dcache_busy(dcache_busy), .read_ack(read_ack), .write_ack(write_ack),
      .rdata_val(rdata_val), .rdata(rdata),
      .read_req(read_req), .write_req(write_req), .addr(addr),
      .write_data(write_data), .timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clr();
      p0_read_req = 0; p1_read_req = 0; p0_write_req = 0; p1_write_req = 0;
      p0_addr = 0; p1_addr = 0; p0_write_data = 0; p1_write_data = 0;
      dcache_busy = 0; read_ack = 0; write_ack = 0; rdata_val = 0; rdata = 0;
   endtask

   // drive at the falling edge, sample 1ns later; the rising edge commits
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      clr();
      srst_n = 1'b1;
      // reset with dcache_busy high: every output low except rdata_out
      #2 srst_n = 1'b0; dcache_busy = 1; rdata = 32'h12345678;
      #1;
      chk("rst_p0_busy", {31'd0, p0_busy}, 0);
      chk("rst_p1_busy", {31'd0, p1_busy}, 0);
      chk("rst_read_req", {31'd0, read_req}, 0);
      chk("rst_timeout", {31'd0, timeout_err}, 0);
      chk("rst_rdata_out", rdata_out, 32'h12345678);
      cyc(); srst_n = 1'b1; clr(); #1;
      chk("post_rst_p0_busy", {31'd0, p0_busy}, 0);

      // tie from reset: p0 write vs p1 read, p0 wins
      cyc(); p0_write_req = 4'hF; p0_addr = 32'h200; p0_write_data = 32'h11111111;
      p1_read_req = 1; p1_addr = 32'h300; #1;
      chk("tie_idle_p1_busy", {31'd0, p1_busy}, 0);
      chk("tie_idle_read_req", {31'd0, read_req}, 0);
      cyc(); #1;
      chk("tie_own_addr", addr, 32'h200);
      chk("tie_own_wr", {28'd0, write_req}, 32'hF);
      chk("tie_own_wdata", write_data, 32'h11111111);
      chk("tie_own_rd_ignored", {31'd0, read_req}, 0);
      chk("tie_own_p1_busy", {31'd0, p1_busy}, 1);
      chk("tie_own_p0_busy", {31'd0, p0_busy}, 1);
      cyc(); write_ack = 1; #1;
      chk("tie_p0_wack", {31'd0, p0_write_ack}, 1);
      chk("tie_p1_wack", {31'd0, p1_write_ack}, 0);
      chk("tie_wack_p1_busy", {31'd0, p1_busy}, 1);
      chk("tie_wack_p0_busy", {31'd0, p0_busy}, 0);
      // repeated tie: p1 now preferred
      cyc(); write_ack = 0; p0_write_req = 4'h3; p0_addr = 32'h204; #1;
      chk("tie2_idle_read_req", {31'd0, read_req}, 0);
      cyc(); read_ack = 1; rdata_val = 1; rdata = 32'hCAFEF00D; #1;
      chk("tie2_addr_p1", addr, 32'h300);
      chk("tie2_read_req", {31'd0, read_req}, 1);
      chk("tie2_p0_busy", {31'd0, p0_busy}, 1);
      // read_ack + rdata_val together complete immediately
      chk("same_p1_rack", {31'd0, p1_read_ack}, 1);
      chk("same_p1_rval", {31'd0, p1_rdata_val}, 1);
      chk("same_p0_rval", {31'd0, p0_rdata_val}, 0);
      chk("same_p1_busy", {31'd0, p1_busy}, 0);
      chk("same_rdata_out", rdata_out, 32'hCAFEF00D);
      cyc(); clr(); #1;
      chk("same_back_idle", {31'd0, read_req}, 0);

      // p0 lw at 0x100; stray rdata_val in OWN dropped
      cyc(); p0_read_req = 1; p0_addr = 32'h100; #1;
      chk("lw_c0_read_req", {31'd0, read_req}, 0);
      cyc(); rdata_val = 1; #1;
      chk("lw_c1_read_req", {31'd0, read_req}, 1);
      chk("lw_c1_addr", addr, 32'h100);
      chk("lw_c1_stray_rval", {31'd0, p0_rdata_val}, 0);
      chk("lw_c1_p0_busy", {31'd0, p0_busy}, 1);
      cyc(); rdata_val = 0; read_ack = 1; #1;
      chk("lw_c2_p0_rack", {31'd0, p0_read_ack}, 1);
      chk("lw_c2_p1_rack", {31'd0, p1_read_ack}, 0);
      cyc(); clr(); #1;
      chk("lw_c3_read_req", {31'd0, read_req}, 0);
      chk("lw_c3_p0_busy", {31'd0, p0_busy}, 1);
      cyc(); rdata_val = 1; rdata = 32'hDEADBEEF; #1;
      chk("lw_c4_p0_rval", {31'd0, p0_rdata_val}, 1);
      chk("lw_c4_p1_rval", {31'd0, p1_rdata_val}, 0);
      chk("lw_c4_rdata_out", rdata_out, 32'hDEADBEEF);
      chk("lw_c4_p0_busy", {31'd0, p0_busy}, 0);
      cyc(); clr(); #1;
      chk("lw_c5_p0_rval", {31'd0, p0_rdata_val}, 0);

      // p1 sw byte 2
      cyc(); p1_write_req = 4'b0100; p1_addr = 32'h400; p1_write_data = 32'h00AB0000; #1;
      chk("sw_idle_wr", {28'd0, write_req}, 0);
      cyc(); #1;
      chk("sw_own_wr", {28'd0, write_req}, 32'h4);
      chk("sw_own_wdata", write_data, 32'h00AB0000);
      chk("sw_own_addr", addr, 32'h400);
      cyc(); write_ack = 1; #1;
      chk("sw_p1_wack", {31'd0, p1_write_ack}, 1);
      chk("sw_p0_wack", {31'd0, p0_write_ack}, 0);
      cyc(); clr(); #1;
      chk("sw_back_idle_wr", {28'd0, write_req}, 0);
      chk("sw_back_idle_busy", {31'd0, p1_busy}, 0);

      // read+write from one pipe: read wins, write masked; then abort
      cyc(); p0_read_req = 1; p0_write_req = 4'hF; p0_addr = 32'h500; #1;
      cyc(); #1;
      chk("conf_read_req", {31'd0, read_req}, 1);
      chk("conf_write_req", {28'd0, write_req}, 0);
      cyc(); clr(); #1;
      chk("abort_read_req", {31'd0, read_req}, 0);
      chk("abort_p0_rack", {31'd0, p0_read_ack}, 0);
      // abort left last_grant at p1, so the tie goes to p0
      cyc(); p0_read_req = 1; p0_addr = 32'h600; p1_read_req = 1; p1_addr = 32'h700; #1;
      cyc(); #1;
      chk("abort_tie_addr", addr, 32'h600);
      chk("abort_tie_p1_busy", {31'd0, p1_busy}, 1);
      cyc(); clr(); #1;
      // acks in IDLE are dropped
      cyc(); read_ack = 1; write_ack = 1; rdata_val = 1; #1;
      chk("idle_drop_rack", {31'd0, p0_read_ack | p1_read_ack}, 0);
      chk("idle_drop_wack", {31'd0, p0_write_ack | p1_write_ack}, 0);
      chk("idle_drop_rval", {31'd0, p0_rdata_val | p1_rdata_val}, 0);
      cyc(); clr(); #1;

      // watchdog, TIMEOUT=4
      cyc(); p1_read_req = 1; p1_addr = 32'h800; #1;
      cyc(); read_ack = 1; #1;
      chk("to_p1_rack", {31'd0, p1_read_ack}, 1);
      for (int w = 1; w <= 4; w++) begin
         cyc(); clr(); #1;
         chk($sformatf("to_wait%0d_err", w), {31'd0, timeout_err}, (w == 4) ? 32'd1 : 32'd0);
         chk($sformatf("to_wait%0d_busy", w), {31'd0, p1_busy}, 1);
      end
      cyc(); rdata_val = 1; #1;
      chk("to_late_rval", {31'd0, p1_rdata_val}, 0);
      chk("to_late_err", {31'd0, timeout_err}, 0);
      cyc(); clr(); #1;
      // data in the expiry cycle completes normally
      cyc(); p0_read_req = 1; p0_addr = 32'h900; #1;
      cyc(); read_ack = 1; #1;
      for (int w = 1; w <= 3; w++) begin
         cyc(); clr(); #1;
      end
      cyc(); rdata_val = 1; #1;
      chk("prec_err", {31'd0, timeout_err}, 0);
      chk("prec_p0_rval", {31'd0, p0_rdata_val}, 1);
      cyc(); clr(); #1;

      // reset during WAIT_DATA (last_grant is p0 before reset)
      cyc(); p0_read_req = 1; p0_addr = 32'hA00; #1;
      cyc(); read_ack = 1; #1;
      cyc(); clr(); #1;
      cyc(); srst_n = 0; dcache_busy = 1; rdata_val = 1; rdata = 32'h55AA55AA; #1;
      chk("wrst_p0_busy", {31'd0, p0_busy}, 0);
      chk("wrst_p0_rval", {31'd0, p0_rdata_val}, 0);
      chk("wrst_timeout", {31'd0, timeout_err}, 0);
      chk("wrst_rdata_out", rdata_out, 32'h55AA55AA);
      cyc(); clr(); srst_n = 1; p0_read_req = 1; p0_addr = 32'hB00;
      p1_read_req = 1; p1_addr = 32'hC00; #1;
      cyc(); #1;
      chk("wrst_tie_addr", addr, 32'hB00);
      chk("wrst_tie_read_req", {31'd0, read_req}, 1);
      cyc(); read_ack = 1; rdata_val = 1; #1;
      chk("wrst_p0_rack", {31'd0, p0_read_ack}, 1);
      cyc(); clr(); #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
